output_port_arbiter: RTL and testbench

- Per-output-port controller for the dynamic router. It shares one router output port among all input units.
- It arbitrates packet-level ownership round-robin and holds ownership from head flit to tail flit.
- It tracks downstream input-queue space with a credit counter and registers the selected flit onto the output link.
- One instance sits after each output port's crossbar column.

---
 rtl/output_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_output_port_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/output_port_arbiter.sv
// rtl/output_port_arbiter.sv - per-output-port packet arbiter with credit-based flow control
module output_port_arbiter #(
  parameter int N_IN       = 7,
  parameter int SEL_W      = 3,
  parameter int FLIT_SIZE  = 64,
  parameter int CREDIT_MAX = 16,
  parameter int CREDIT_W   = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_IN-1:0]           req_i,
  input  logic [N_IN-1:0]           req_tail_i,
  input  logic [N_IN*FLIT_SIZE-1:0] data_i,
  input  logic                      credit_i,
  output logic [N_IN-1:0]           grant_o,
  output logic [FLIT_SIZE-1:0]      data_o,
  output logic                      valid_o,
  output logic [SEL_W-1:0]          owner_o,
  output logic                      busy_o,
  output logic [CREDIT_W-1:0]       credits_o,
  output logic                      credit_err_o
);

  localparam logic [CREDIT_W-1:0] CMAX = CREDIT_W'(CREDIT_MAX);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e               state_q;
  logic [SEL_W-1:0]     rr_ptr_q;
  logic [SEL_W-1:0]     owner_q;
  logic [CREDIT_W-1:0]  credits_q;
  logic [CREDIT_W-1:0]  credits_d;
  logic                 credit_err_q;
  logic                 valid_q;
  logic [FLIT_SIZE-1:0] data_q;

  logic                 owner_req;
  logic                 owner_tail;
  logic [FLIT_SIZE-1:0] owner_flit;
  logic                 hi_found;
  logic [SEL_W-1:0]     hi_idx;
  logic [SEL_W-1:0]     lo_idx;
  logic [SEL_W-1:0]     pick;
  logic                 any_req;
  logic                 xfer;

  // Owner-indexed view of the request, tail flag and flit (constant indices only)
  always_comb begin
    owner_req  = 1'b0;
    owner_tail = 1'b0;
    owner_flit = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (owner_q == SEL_W'(i)) begin
        owner_req  = req_i[i];
        owner_tail = req_tail_i[i];
        owner_flit = data_i[i*FLIT_SIZE +: FLIT_SIZE];
      end
    end
  end

  // Round-robin pick: lowest request at or above rr_ptr, else lowest request overall (wrap)
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_idx = SEL_W'(i);
        if (SEL_W'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = SEL_W'(i);
        end
      end
    end
    pick = hi_found ? hi_idx : lo_idx;
  end

  assign any_req = |req_i;

  // Dequeue strobe to the owner only while it has a flit and downstream has room
  always_comb begin
    grant_o = '0;
    if (state_q == LOCKED && owner_req && credits_q != '0) begin
      for (int i = 0; i < N_IN; i++) begin
        if (owner_q == SEL_W'(i)) grant_o[i] = 1'b1;
      end
    end
  end

  assign xfer = |grant_o;

  // Credit count: a transfer consumes, a returned credit restores, both cancel; saturate at max
  always_comb begin
    credits_d = credits_q;
    if (xfer && !credit_i) begin
      credits_d = credits_q - CREDIT_W'(1);
    end else if (!xfer && credit_i && credits_q != CMAX) begin
      credits_d = credits_q + CREDIT_W'(1);
    end
  end

  // Ownership FSM with registered link output, credit counter and sticky overflow flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      credits_q    <= CMAX;
      credit_err_q <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
    end else begin
      credits_q <= credits_d;
      if (credit_i && credits_q == CMAX) credit_err_q <= 1'b1;
      valid_q <= xfer;
      if (xfer) data_q <= owner_flit;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q <= pick;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer && owner_tail) begin
            state_q  <= IDLE;
            rr_ptr_q <= (owner_q == SEL_W'(N_IN - 1)) ? '0 : owner_q + SEL_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign owner_o      = owner_q;
  assign busy_o       = (state_q == LOCKED);
  assign credits_o    = credits_q;
  assign credit_err_o = credit_err_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// tb/tb_output_port_arbiter.sv - scoreboard bench for output_port_arbiter
module tb_output_port_arbiter;

  localparam int N  = 7;
  localparam int FW = 64;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  req_tail;
  logic [N*FW-1:0] data_in;
  logic          credit_in;
  logic [N-1:0]  grant;
  logic [FW-1:0] data_out;
  logic          valid_out;
  logic [2:0]    owner;
  logic          busy;
  logic [4:0]    credits;
  logic          credit_err;

  output_port_arbiter dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .req_tail_i   (req_tail),
    .data_i       (data_in),
    .credit_i     (credit_in),
    .grant_o      (grant),
    .data_o       (data_out),
    .valid_o      (valid_out),
    .owner_o      (owner),
    .busy_o       (busy),
    .credits_o    (credits),
    .credit_err_o (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Upstream input-unit models: packets remaining, packet length, flit position, total flits
  int src_pkts [N];
  int src_len  [N];
  int src_sent [N];
  int src_tot  [N];

  logic [FW-1:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] flit_val(input int i, input int n);
    return {16'hC0DE, 16'(i), 32'(n)};
  endfunction

  task automatic add_src(input int i, input int pkts, input int len);
    src_pkts[i] = pkts;
    src_len[i]  = len;
    src_sent[i] = 0;
  endtask

  // One cycle: drive sources, check grant, push expected flit, clock, check link output
  task automatic step(input logic [N-1:0] exp_g, input logic [N-1:0] bub, input logic cin);
    logic [N-1:0]  g;
    logic [FW-1:0] exp_d;
    for (int i = 0; i < N; i++) begin
      if (src_pkts[i] > 0 && !bub[i]) begin
        req[i]      = 1'b1;
        req_tail[i] = (src_sent[i] == src_len[i] - 1);
        data_in[i*FW +: FW] = flit_val(i, src_tot[i]);
      end else begin
        req[i]      = 1'b0;
        req_tail[i] = 1'b0;
        data_in[i*FW +: FW] = '0;
      end
    end
    credit_in = cin;
    #1;
    check_eq("grant", 64'(grant), 64'(exp_g));
    for (int i = 0; i < N; i++) begin
      if (exp_g[i]) exp_q.push_back(flit_val(i, src_tot[i]));
    end
    g = grant;
    for (int i = 0; i < N; i++) begin
      if (g[i] && src_pkts[i] > 0) begin
        src_tot[i]++;
        src_sent[i]++;
        if (src_sent[i] == src_len[i]) begin
          src_pkts[i]--;
          src_sent[i] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    credit_in = 1'b0;
    if (exp_q.size() > 0) begin
      exp_d = exp_q.pop_front();
      check_eq("valid_out", 64'(valid_out), 64'd1);
      check_eq("data_out", data_out, exp_d);
    end else begin
      check_eq("valid_out_idle", 64'(valid_out), 64'd0);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    req_tail  = '0;
    data_in   = '0;
    credit_in = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      src_pkts[i] = 0;
      src_len[i]  = 1;
      src_sent[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_owner", 64'(owner), 64'd0);
    check_eq("rst_credits", 64'(credits), 64'd16);
    check_eq("rst_valid", 64'(valid_out), 64'd0);
    check_eq("rst_data", data_out, 64'd0);
    check_eq("rst_err", 64'(credit_err), 64'd0);
    check_eq("rst_grant", 64'(grant), 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) src_tot[i] = 0;
    do_reset();

    // Single requester, 3-flit packet on input 2
    add_src(2, 1, 3);
    step(7'b0000000, '0, 1'b0);
    check_eq("t1_owner", 64'(owner), 64'd2);
    check_eq("t1_busy", 64'(busy), 64'd1);
    repeat (3) step(7'b0000100, '0, 1'b0);
    check_eq("t1_busy_end", 64'(busy), 64'd0);
    check_eq("t1_credits", 64'(credits), 64'd13);
    // rr_ptr is now 3: input 4 must win over input 1
    add_src(1, 1, 1);
    add_src(4, 1, 1);
    step(7'b0000000, '0, 1'b0);
    step(7'b0010000, '0, 1'b0);
    step(7'b0000000, '0, 1'b0);
    step(7'b0000010, '0, 1'b0);
    step(7'b0000000, '0, 1'b0);

    // Round-robin fairness among inputs 0, 3, 6
    do_reset();
    add_src(0, 2, 1);
    add_src(3, 2, 1);
    add_src(6, 2, 1);
    for (int r = 0; r < 2; r++) begin
      step(7'b0000000, '0, 1'b0);
      step(7'b0000001, '0, 1'b0);
      step(7'b0000000, '0, 1'b0);
      step(7'b0001000, '0, 1'b0);
      step(7'b0000000, '0, 1'b0);
      step(7'b1000000, '0, 1'b0);
    end
    step(7'b0000000, '0, 1'b0);

    // No interleaving: input 1 4-flit packet with a bubble, input 5 waiting
    do_reset();
    add_src(1, 1, 4);
    add_src(5, 1, 1);
    step(7'b0000000, '0, 1'b0);
    step(7'b0000010, '0, 1'b0);
    step(7'b0000010, '0, 1'b0);
    step(7'b0000000, 7'b0000010, 1'b0);
    check_eq("t3_busy_bubble", 64'(busy), 64'd1);
    step(7'b0000010, '0, 1'b0);
    step(7'b0000010, '0, 1'b0);
    step(7'b0000000, '0, 1'b0);
    step(7'b0100000, '0, 1'b0);
    step(7'b0000000, '0, 1'b0);

    // Credit exhaustion on a 20-flit packet, then credit return
    do_reset();
    add_src(0, 1, 20);
    step(7'b0000000, '0, 1'b0);
    repeat (16) step(7'b0000001, '0, 1'b0);
    check_eq("t4_credits_zero", 64'(credits), 64'd0);
    step(7'b0000000, '0, 1'b0);
    check_eq("t4_busy_blocked", 64'(busy), 64'd1);
    step(7'b0000000, '0, 1'b1);
    check_eq("t4_credits_one", 64'(credits), 64'd1);
    step(7'b0000001, '0, 1'b0);
    step(7'b0000000, '0, 1'b0);
    repeat (5) step(7'b0000000, 7'b0000001, 1'b1);
    check_eq("t5_credits_five", 64'(credits), 64'd5);
    step(7'b0000001, '0, 1'b1);
    check_eq("t5_credits_same", 64'(credits), 64'd5);
    step(7'b0000001, '0, 1'b0);
    step(7'b0000001, '0, 1'b0);
    check_eq("t5_credits_end", 64'(credits), 64'd3);
    check_eq("t5_busy_end", 64'(busy), 64'd0);
    step(7'b0000000, '0, 1'b0);

    // Overflow, then asynchronous reset mid-packet
    do_reset();
    step(7'b0000000, '0, 1'b1);
    check_eq("t6_credits_sat", 64'(credits), 64'd16);
    check_eq("t6_err_set", 64'(credit_err), 64'd1);
    add_src(2, 1, 4);
    step(7'b0000000, '0, 1'b0);
    step(7'b0000100, '0, 1'b0);
    step(7'b0000100, '0, 1'b0);
    check_eq("t6_err_sticky", 64'(credit_err), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_busy", 64'(busy), 64'd0);
    check_eq("t6_async_credits", 64'(credits), 64'd16);
    check_eq("t6_async_err", 64'(credit_err), 64'd0);
    check_eq("t6_async_valid", 64'(valid_out), 64'd0);
    check_eq("t6_async_grant", 64'(grant), 64'd0);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
